// File: rtl/signed_booth_multiplier.sv
// Radix-2 Booth sequential signed multiplier: one Booth step per clock, free-running LOAD/ITER loop.
// Optional `SIGNED_BOOTH_DONE_EN adds a one-cycle done pulse after each result update.
module signed_booth_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Q,
`ifdef SIGNED_BOOTH_DONE_EN
  output logic                 done,
`endif
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {LOAD, ITER} state_t;

  state_t            state, state_next;
  logic [WIDTH:0]    a_reg, m_reg, a_sum;
  logic [WIDTH-1:0]  q_reg;
  logic              q_m1;
  logic [CW-1:0]     cnt;
  logic              load_en, last_step;
  logic [2*WIDTH:0]  shifted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    state_next = ITER;
      ITER:    if (last_step) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_comb begin
    load_en   = (state == LOAD);
    last_step = (state == ITER) && (cnt == CW'(WIDTH - 1));
  end

  // Booth recode, then arithmetic shift of {A', Qreg} with A's sign bit replicated.
  always_comb begin
    a_sum = a_reg;
    case ({q_reg[0], q_m1})
      2'b10:   a_sum = a_reg - m_reg;
      2'b01:   a_sum = a_reg + m_reg;
      default: a_sum = a_reg;
    endcase
    shifted = {a_sum[WIDTH], a_sum, q_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      m_reg  <= '0;
      q_reg  <= '0;
      q_m1   <= 1'b0;
      cnt    <= '0;
      result <= '0;
`ifdef SIGNED_BOOTH_DONE_EN
      done   <= 1'b0;
`endif
    end else begin
`ifdef SIGNED_BOOTH_DONE_EN
      done <= last_step;
`endif
      if (load_en) begin
        a_reg <= '0;
        m_reg <= {M[WIDTH-1], M};
        q_reg <= Q;
        q_m1  <= 1'b0;
        cnt   <= '0;
      end else begin
        a_reg <= shifted[2*WIDTH:WIDTH];
        q_reg <= shifted[WIDTH-1:0];
        q_m1  <= q_reg[0];
        cnt   <= cnt + CW'(1);
        if (last_step) result <= shifted[2*WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_signed_booth_multiplier.sv
// Self-checking bench for signed_booth_multiplier (WIDTH=4): phase-counting product model,
// per-cycle compare process, literal anchor cases, mid-operation reset and exhaustive sweep.
module tb_signed_booth_multiplier;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   m = '0;
  logic [W-1:0]   q = '0;
  logic [2*W-1:0] result;
`ifdef SIGNED_BOOTH_DONE_EN
  logic           done;
`endif

  always #5 clk = ~clk;

  signed_booth_multiplier #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .M      (m),
    .Q      (q),
`ifdef SIGNED_BOOTH_DONE_EN
    .done   (done),
`endif
    .result (result)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Model: operands captured every (W+1)th edge after reset, product visible W edges later.
  int unsigned    phase;
  logic [W-1:0]   lm, lq;
  logic [2*W-1:0] exp_res;
  logic           exp_done;

  function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int pa, pb;
    pa = int'($signed(a));
    pb = int'($signed(b));
    return (2*W)'(pa * pb);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= 0;
      exp_res  <= '0;
      exp_done <= 1'b0;
      lm       <= '0;
      lq       <= '0;
    end else begin
      exp_done <= 1'b0;
      if (phase == 0) begin
        lm <= m;
        lq <= q;
      end
      if (phase == W) begin
        exp_res  <= prod(lm, lq);
        exp_done <= 1'b1;
      end
      phase <= (phase == W) ? 0 : phase + 1;
    end
  end

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    check("result_vs_model", result, exp_res);
`ifdef SIGNED_BOOTH_DONE_EN
    check("done_vs_model", {{(2*W-1){1'b0}}, done}, {{(2*W-1){1'b0}}, exp_done});
`endif
  end

  // Called at a negedge; returns at a negedge where the next edge is a LOAD edge.
  task automatic wait_load();
    for (int i = 0; i <= W + 1; i++) begin
      if (phase == 0) break;
      @(negedge clk);
    end
    if (phase != 0) begin
      fails++;
      tests++;
      $display("FAIL wait_load: phase %0d expected 0", phase);
    end
  endtask

  task automatic run_pair(input logic [W-1:0] mv, input logic [W-1:0] qv,
                          input logic [2*W-1:0] lit, input string name);
    wait_load();
    m = mv;
    q = qv;
    repeat (W + 1) @(negedge clk);
    check({name, "_model"}, exp_res, lit);
    check({name, "_dut"}, result, lit);
  endtask

  initial begin
    m = 4'b1001;
    q = 4'b0110;
    repeat (3) @(negedge clk);
    check("reset_result", result, 8'h00);
    rst = 1'b0;
    repeat (W) @(negedge clk);
    check("before_first", result, 8'h00);
    @(negedge clk);
    check("first_m7x6", result, 8'hD6);

    run_pair(4'b1000, 4'b1000, 8'h40, "min_x_min");
    run_pair(4'd7,    4'd7,    8'h31, "p7_x_p7");
    run_pair(4'd7,    4'b1000, 8'hC8, "p7_x_min");
    run_pair(4'b1111, 4'd1,    8'hFF, "m1_x_p1");
    run_pair(4'd0,    4'b1011, 8'h00, "zero_x_m5");

    // Operands changed mid-operation must not disturb the product in flight.
    wait_load();
    m = 4'd3;
    q = 4'd5;
    repeat (2) @(negedge clk);
    m = 4'b1110;
    q = 4'd4;
    repeat (W - 1) @(negedge clk);
    check("midchange_cur", result, 8'h0F);
    repeat (W + 1) @(negedge clk);
    check("midchange_next", result, 8'hF8);

    // Reset in the middle of an operation clears result at once.
    run_pair(4'b1001, 4'd6, 8'hD6, "pre_reset");
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", result, 8'h00);
    @(negedge clk);
    m = 4'd6;
    q = 4'b1101;
    rst = 1'b0;
    repeat (W + 1) @(negedge clk);
    check("after_reset", result, 8'hEE);

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      m = W'($urandom);
      q = W'($urandom);
    end

    for (int i = 0; i < 256; i++) begin
      logic [7:0] idx;
      idx = 8'(i);
      wait_load();
      m = idx[7:4];
      q = idx[3:0];
      repeat (W + 1) @(negedge clk);
      check("sweep", result, prod(idx[7:4], idx[3:0]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
